fetcher: RTL and testbench

- Instruction-fetch front end. Paired with the pc unit on the fetch interface.
- Takes the next fetch address from pc and reads the instruction word through the memory-controller port.
- Hands each fetched {pc, inst} back to pc so it can compute the following address, and buffers fetched instructions in a small FIFO for issue.
- Flushes the FIFO and discards any in-flight fetch on rollback.

---
 rtl/fetcher_if.sv | 37 +++
 rtl/fetcher.sv | 141 ++++++++++++++
 tb/tb_fetcher.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetcher_if.sv
// Fetch-side bundle: pc unit hand-off, memory-controller port and issue queue head.
// The fetcher uses the master view; the pc/memory/issue environment uses the slave view.
interface fetcher_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_next_pc;
  logic              in_next_taken;
  logic              in_rollback;
  logic              out_pc_ena;
  logic [DATA_W-1:0] out_last_pc;
  logic [DATA_W-1:0] out_last_inst;
  logic              out_mem_req;
  logic [DATA_W-1:0] out_mem_addr;
  logic              in_mem_ready;
  logic [DATA_W-1:0] in_mem_data;
  logic              out_inst_valid;
  logic [DATA_W-1:0] out_inst;
  logic [DATA_W-1:0] out_inst_pc;
  logic              out_inst_taken;
  logic              in_issue_ready;

  modport master (
    input  in_next_pc, in_next_taken, in_rollback,
    input  in_mem_ready, in_mem_data, in_issue_ready,
    output out_pc_ena, out_last_pc, out_last_inst,
    output out_mem_req, out_mem_addr,
    output out_inst_valid, out_inst, out_inst_pc, out_inst_taken
  );

  modport slave (
    output in_next_pc, in_next_taken, in_rollback,
    output in_mem_ready, in_mem_data, in_issue_ready,
    input  out_pc_ena, out_last_pc, out_last_inst,
    input  out_mem_req, out_mem_addr,
    input  out_inst_valid, out_inst, out_inst_pc, out_inst_taken
  );
endinterface

// File: rtl/fetcher.sv
// Instruction-fetch front end: one outstanding memory read at a time, result handed back
// to pc and buffered in a small instruction queue; rollback flushes everything in flight.
//
// state | meaning
// IDLE  | no request outstanding; issue one when the queue has room and no rollback
// WAIT  | request outstanding; wait for in_mem_ready (word dropped if discard is set)
module fetcher #(
  parameter int DATA_W   = 32,
  parameter int IQ_DEPTH = 4,
  parameter int IQ_AW    = 2
) (
  input logic clk,
  input logic rst,
  input logic ena,
  fetcher_if.master bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [IQ_AW:0] FULL_CNT = (IQ_AW+1)'(IQ_DEPTH);

  state_t            state_q, state_d;
  logic              discard_q, discard_d;
  logic              mem_req_q, mem_req_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;

  logic [IQ_AW-1:0]  head_q, head_d;
  logic [IQ_AW-1:0]  tail_q, tail_d;
  logic [IQ_AW:0]    count_q, count_d;

  logic [DATA_W-1:0] iq_inst_q  [IQ_DEPTH];
  logic [DATA_W-1:0] iq_pc_q    [IQ_DEPTH];
  logic              iq_taken_q [IQ_DEPTH];

  logic accept;
  logic push;
  logic pop;
  logic iq_valid;

  assign iq_valid = (count_q != '0);

  // A word returned after a rollback (now or earlier in this WAIT) belongs to the wrong path.
  assign accept = ena && (state_q == WAIT) && bus.in_mem_ready
                  && !discard_q && !bus.in_rollback;
  assign push   = accept;
  assign pop    = ena && iq_valid && bus.in_issue_ready && !bus.in_rollback;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      discard_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      discard_q  <= discard_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    discard_d  = discard_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if ((count_q < FULL_CNT) && !bus.in_rollback) begin
            mem_req_d  = 1'b1;
            mem_addr_d = bus.in_next_pc;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (bus.in_mem_ready) begin
            mem_req_d = 1'b0;
            discard_d = 1'b0;
            state_d   = IDLE;
          end else if (bus.in_rollback) begin
            discard_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (ena) begin
      if (bus.in_rollback) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (pop) begin
          head_d = head_q + 1'b1;
        end
        if (push) begin
          tail_d = tail_q + 1'b1;
        end
        unique case ({push, pop})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end
    end
  end

  // Entry storage needs no reset: head outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      iq_inst_q[tail_q]  <= bus.in_mem_data;
      iq_pc_q[tail_q]    <= mem_addr_q;
      iq_taken_q[tail_q] <= bus.in_next_taken;
    end
  end

  assign bus.out_pc_ena    = accept;
  assign bus.out_last_pc   = accept ? mem_addr_q : '0;
  assign bus.out_last_inst = accept ? bus.in_mem_data : '0;

  assign bus.out_mem_req   = mem_req_q;
  assign bus.out_mem_addr  = mem_addr_q;

  assign bus.out_inst_valid = iq_valid;
  assign bus.out_inst       = iq_valid ? iq_inst_q[head_q] : '0;
  assign bus.out_inst_pc    = iq_valid ? iq_pc_q[head_q] : '0;
  assign bus.out_inst_taken = iq_valid ? iq_taken_q[head_q] : 1'b0;

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: pc and memory models drive the fetch side, a scoreboard
// queue holds expected {inst, pc, taken} entries and is checked as the DUT pops them.
module tb_fetcher;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        taken;
  } exp_t;

  logic clk;
  logic rst;
  logic ena;

  fetcher_if #(.DATA_W(32)) bus ();

  fetcher #(.DATA_W(32), .IQ_DEPTH(4), .IQ_AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  // pc predicts "taken" from bit 3 of the address it is handed back
  assign bus.in_next_taken = bus.out_last_pc[3];

  int checks = 0;
  int errors = 0;
  int pc_ena_cnt = 0;
  int pop_cnt = 0;
  int req_rises = 0;
  int mem_cnt = 0;
  int load_seq = 0;
  int load_seen = 0;
  logic [31:0] model_pc = 32'h0;
  logic [31:0] load_pc = 32'h0;
  logic [31:0] last_req_addr = 32'h0;
  bit mem_const = 1'b1;
  bit mem_on = 1'b1;
  bit s_pc_ena = 1'b0;
  bit prev_req = 1'b0;
  bit ready_was = 1'b0;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return mem_const ? 32'h0000_0013 : (a ^ 32'hC0DE_0000);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req_rise(string tag);
    logic p;
    bit seen;
    seen = 1'b0;
    p = bus.out_mem_req;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      seen = bus.out_mem_req && !p;
      p = bus.out_mem_req;
    end
    chk1({tag, "_req_to"}, seen, 1'b1);
  endtask

  task automatic wait_pc_ena(string tag);
    int n0;
    n0 = pc_ena_cnt;
    for (int i = 0; i < 100 && pc_ena_cnt == n0; i++) step();
    chk1({tag, "_pcena_to"}, pc_ena_cnt > n0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.in_rollback = 1'b0;
    bus.in_issue_ready = 1'b0;
    load_pc = 32'h0;
    load_seq++;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  // pc model, memory model (2-cycle latency) and scoreboard monitor
  initial begin
    bus.in_mem_ready = 1'b0;
    bus.in_mem_data  = 32'hDEAD_BEEF;
    bus.in_next_pc   = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      ready_was = bus.in_mem_ready;
      bus.in_mem_ready = 1'b0;
      if (load_seq != load_seen) begin
        model_pc  = load_pc;
        load_seen = load_seq;
      end else if (s_pc_ena) begin
        model_pc = model_pc + 32'd4;
      end
      bus.in_next_pc = model_pc;
      if (!rst) begin
        mem_cnt = 0;
      end else if (ena) begin
        if (!bus.out_mem_req || ready_was) begin
          mem_cnt = 0;
        end else if (mem_on) begin
          mem_cnt++;
          if (mem_cnt >= 2) begin
            bus.in_mem_ready = 1'b1;
            bus.in_mem_data  = mem_word(bus.out_mem_addr);
            mem_cnt = 0;
          end
        end
      end

      @(negedge clk);
      s_pc_ena = bus.out_pc_ena;
      if (!rst) begin
        sb.delete();
        prev_req  = 1'b0;
        req_rises = 0;
      end else begin
        chk1("q_valid", bus.out_inst_valid, sb.size() != 0);
        if (bus.out_mem_req && !prev_req) begin
          req_rises++;
          last_req_addr = bus.out_mem_addr;
        end
        prev_req = bus.out_mem_req;
        if (bus.out_pc_ena) begin
          pc_ena_cnt++;
          chk("last_pc", bus.out_last_pc, model_pc);
          chk("last_inst", bus.out_last_inst, mem_word(model_pc));
        end
        if (bus.in_rollback) begin
          sb.delete();
        end else begin
          if (ena && bus.out_inst_valid && bus.in_issue_ready && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            pop_cnt++;
            chk("head_inst", bus.out_inst, e.inst);
            chk("head_pc", bus.out_inst_pc, e.pc);
            chk1("head_taken", bus.out_inst_taken, e.taken);
          end
          if (bus.out_pc_ena) begin
            sb.push_back('{inst: mem_word(model_pc), pc: model_pc, taken: model_pc[3]});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int n0;
    int p0;
    rst = 1'b0;
    ena = 1'b0;
    bus.in_rollback = 1'b0;
    bus.in_issue_ready = 1'b0;
    #3;
    chk1("rst_req", bus.out_mem_req, 1'b0);
    chk("rst_addr", bus.out_mem_addr, 32'h0);
    chk1("rst_valid", bus.out_inst_valid, 1'b0);
    chk1("rst_pc_ena", bus.out_pc_ena, 1'b0);
    chk("rst_last_pc", bus.out_last_pc, 32'h0);
    chk("rst_last_inst", bus.out_last_inst, 32'h0);
    chk("rst_inst", bus.out_inst, 32'h0);
    chk("rst_inst_pc", bus.out_inst_pc, 32'h0);
    chk1("rst_inst_taken", bus.out_inst_taken, 1'b0);
    step();
    rst = 1'b1;
    step();
    ena = 1'b1;

    // sequential fetch of 0x0, 0x4, 0x8
    n0 = pc_ena_cnt;
    for (int i = 0; i < 200 && pc_ena_cnt < n0 + 3; i++) step();
    chk1("t1_to", pc_ena_cnt >= n0 + 3, 1'b1);
    chk("t1_head_pc", bus.out_inst_pc, 32'h0);
    chk("t1_head_inst", bus.out_inst, 32'h0000_0013);
    bus.in_issue_ready = 1'b1;
    repeat (30) step();
    bus.in_issue_ready = 1'b0;
    chk1("t1_pops", pop_cnt >= 3, 1'b1);

    // queue fill then a single pop
    mem_const = 1'b0;
    do_reset();
    repeat (40) step();
    chk("t2_reqs", req_rises, 4);
    chk("t2_last_addr", last_req_addr, 32'hC);
    chk1("t2_req_low", bus.out_mem_req, 1'b0);
    chk1("t2_valid", bus.out_inst_valid, 1'b1);
    bus.in_issue_ready = 1'b1;
    step();
    bus.in_issue_ready = 1'b0;
    repeat (20) step();
    chk("t2_reqs_after_pop", req_rises, 5);
    chk("t2_addr_after_pop", last_req_addr, 32'h10);
    chk1("t2_req_low2", bus.out_mem_req, 1'b0);

    // rollback while waiting on 0x8
    do_reset();
    for (int i = 0; i < 100 && !(bus.out_mem_req && bus.out_mem_addr == 32'h8 && !bus.in_mem_ready); i++)
      step();
    chk1("t3_to", bus.out_mem_req && bus.out_mem_addr == 32'h8, 1'b1);
    chk1("t3_valid_before", bus.out_inst_valid, 1'b1);
    bus.in_rollback = 1'b1;
    load_pc = 32'h40;
    load_seq++;
    step();
    bus.in_rollback = 1'b0;
    #1;
    chk1("t3_drop_pc_ena", bus.out_pc_ena, 1'b0);
    chk1("t3_flushed", bus.out_inst_valid, 1'b0);
    wait_req_rise("t3");
    chk("t3_new_addr", bus.out_mem_addr, 32'h40);
    wait_pc_ena("t3");

    // rollback coincident with in_mem_ready
    for (int i = 0; i < 100 && !bus.in_mem_ready; i++) step();
    chk1("t4_to", bus.in_mem_ready, 1'b1);
    bus.in_rollback = 1'b1;
    load_pc = 32'h80;
    load_seq++;
    #1;
    chk1("t4_pc_ena", bus.out_pc_ena, 1'b0);
    step();
    bus.in_rollback = 1'b0;
    chk1("t4_flushed", bus.out_inst_valid, 1'b0);
    wait_req_rise("t4");
    chk("t4_new_addr", bus.out_mem_addr, 32'h80);

    // ena low freezes the outstanding request
    ena = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk1("ena_req_hold", bus.out_mem_req, 1'b1);
      chk("ena_addr_hold", bus.out_mem_addr, 32'h80);
      chk1("ena_no_pc_ena", bus.out_pc_ena, 1'b0);
    end
    ena = 1'b1;
    wait_pc_ena("ena");
    step();
    chk("ena_head_pc", bus.out_inst_pc, 32'h80);

    // simultaneous push/pop at count 2 across pointer wrap
    do_reset();
    for (int i = 0; i < 100 && sb.size() < 2; i++) step();
    chk1("t5_fill_to", bus.out_inst_valid, 1'b1);
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 100 && !bus.in_mem_ready; i++) step();
      chk1("t5_ready_to", bus.in_mem_ready, 1'b1);
      bus.in_issue_ready = 1'b1;
      step();
      bus.in_issue_ready = 1'b0;
      chk1("t5_valid", bus.out_inst_valid, 1'b1);
    end
    mem_on = 1'b0;
    p0 = pop_cnt;
    bus.in_issue_ready = 1'b1;
    repeat (8) step();
    bus.in_issue_ready = 1'b0;
    chk("t5_depth", pop_cnt - p0, 2);
    chk1("t5_empty", bus.out_inst_valid, 1'b0);
    mem_on = 1'b1;

    // asynchronous reset mid-WAIT with three queued
    do_reset();
    for (int i = 0; i < 100 && !(sb.size() == 3 && bus.out_mem_req); i++) step();
    chk1("t6_to", bus.out_mem_req && bus.out_inst_valid, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk1("t6_req", bus.out_mem_req, 1'b0);
    chk("t6_addr", bus.out_mem_addr, 32'h0);
    chk1("t6_valid", bus.out_inst_valid, 1'b0);
    chk("t6_inst_pc", bus.out_inst_pc, 32'h0);
    chk("t6_inst", bus.out_inst, 32'h0);
    load_pc = 32'h0;
    load_seq++;
    step();
    step();
    rst = 1'b1;
    wait_req_rise("t6");
    chk("t6_restart_addr", bus.out_mem_addr, 32'h0);
    wait_pc_ena("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
